time_keeper: RTL and testbench

TIME_KEEPER -- requirements
Module: time_keeper

---
 rtl/time_keeper_pkg.sv | 22 ++
 rtl/time_keeper_mod_counter.sv | 26 ++
 rtl/time_keeper.sv | 89 ++++++++
 tb/tb_time_keeper.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/time_keeper_pkg.sv
// Shared limits, field widths and load validation for the time-of-day keeper.
package time_keeper_pkg;

  localparam int HOURS_W   = 5;
  localparam int MINUTES_W = 6;
  localparam int SECONDS_W = 6;
  localparam int PRESC_W   = 8;

  localparam logic [HOURS_W-1:0]   MAX_HOURS   = 5'd23;
  localparam logic [MINUTES_W-1:0] MAX_MINUTES = 6'd59;
  localparam logic [SECONDS_W-1:0] MAX_SECONDS = 6'd59;

  localparam int HOURS_MOD   = int'(MAX_HOURS) + 1;
  localparam int MINUTES_MOD = int'(MAX_MINUTES) + 1;
  localparam int SECONDS_MOD = int'(MAX_SECONDS) + 1;

  function automatic logic load_in_range(input logic [HOURS_W-1:0]   h,
                                         input logic [MINUTES_W-1:0] m);
    return (h <= MAX_HOURS) && (m <= MAX_MINUTES);
  endfunction

endpackage

// File: rtl/time_keeper_mod_counter.sv
// Modulo-N counter with synchronous load; carry_out flags the wrapping increment.
module mod_counter #(
  parameter int MODULUS = 60,
  parameter int WIDTH   = 6
) (
  input  logic             input_clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             carry_out
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  // Load takes priority so a time set never also advances on the same edge.
  always_ff @(posedge input_clock or posedge reset) begin
    if (reset)          count <= '0;
    else if (load)      count <= load_value;
    else if (enable)    count <= (count == LAST) ? '0 : count + WIDTH'(1);
  end

  assign carry_out = enable & (count == LAST);

endmodule

// File: rtl/time_keeper.sv
// Hours/minutes/seconds clock advanced by tick_in rising edges, with validated time load.
module time_keeper
  import time_keeper_pkg::*;
#(
  parameter int ticks_per_second = 2
) (
  input  logic                 input_clock,
  input  logic                 reset,
  input  logic                 tick_in,
  input  logic                 load,
  input  logic [HOURS_W-1:0]   load_hours,
  input  logic [MINUTES_W-1:0] load_minutes,
  output logic [HOURS_W-1:0]   hours,
  output logic [MINUTES_W-1:0] minutes,
  output logic [SECONDS_W-1:0] seconds,
  output logic                 second_pulse,
  output logic                 load_error
);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(ticks_per_second - 1);

  logic               tick_d;
  logic [PRESC_W-1:0] prescaler;
  logic               tick_ev;
  logic               load_ok;
  logic               load_bad;
  logic               second_ev;
  logic               sec_carry;
  logic               min_carry;
  logic               hr_carry;

  assign tick_ev   = tick_in & ~tick_d;
  assign load_ok   = load & load_in_range(load_hours, load_minutes);
  assign load_bad  = load & ~load_ok;
  // A valid load pre-empts any coincident second event.
  assign second_ev = tick_ev & (prescaler == PRESC_LAST) & ~load_ok;

  // tick_d resets high so a tick_in already high at release is not an edge.
  always_ff @(posedge input_clock or posedge reset) begin
    if (reset) begin
      tick_d       <= 1'b1;
      prescaler    <= '0;
      second_pulse <= 1'b0;
      load_error   <= 1'b0;
    end else begin
      tick_d       <= tick_in;
      second_pulse <= second_ev;
      load_error   <= load_bad;
      if (load_ok)
        prescaler <= '0;
      else if (tick_ev)
        prescaler <= (prescaler == PRESC_LAST) ? '0 : prescaler + PRESC_W'(1);
    end
  end

  mod_counter #(.MODULUS(SECONDS_MOD), .WIDTH(SECONDS_W)) u_seconds (
    .input_clock (input_clock),
    .reset       (reset),
    .enable      (second_ev),
    .load        (load_ok),
    .load_value  ('0),
    .count       (seconds),
    .carry_out   (sec_carry)
  );

  mod_counter #(.MODULUS(MINUTES_MOD), .WIDTH(MINUTES_W)) u_minutes (
    .input_clock (input_clock),
    .reset       (reset),
    .enable      (sec_carry),
    .load        (load_ok),
    .load_value  (load_minutes),
    .count       (minutes),
    .carry_out   (min_carry)
  );

  mod_counter #(.MODULUS(HOURS_MOD), .WIDTH(HOURS_W)) u_hours (
    .input_clock (input_clock),
    .reset       (reset),
    .enable      (min_carry),
    .load        (load_ok),
    .load_value  (load_hours),
    .count       (hours),
    .carry_out   (hr_carry)
  );

  // Day rollover only happens as the tail of a full seconds/minutes carry chain.
  always_comb assert (!hr_carry || (min_carry && sec_carry));

endmodule

// File: tb/tb_time_keeper.sv
// Randomized and directed checks of time_keeper against a seconds-of-day reference model.
module tb_time_keeper;

  localparam int TPS = 2;

  logic       input_clock = 1'b0;
  logic       reset = 1'b0;
  logic       tick_in = 1'b0;
  logic       load = 1'b0;
  logic [4:0] load_hours = '0;
  logic [5:0] load_minutes = '0;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       second_pulse;
  logic       load_error;

  time_keeper #(.ticks_per_second(TPS)) dut (
    .input_clock  (input_clock),
    .reset        (reset),
    .tick_in      (tick_in),
    .load         (load),
    .load_hours   (load_hours),
    .load_minutes (load_minutes),
    .hours        (hours),
    .minutes      (minutes),
    .seconds      (seconds),
    .second_pulse (second_pulse),
    .load_error   (load_error)
  );

  always #5 input_clock = ~input_clock;

  int n_tests = 0;
  int n_fail  = 0;
  int pulse_cnt = 0;

  // Reference: time of day as seconds since midnight plus a tick count.
  int m_tod  = 0;
  int m_cnt  = 0;
  bit m_prev = 1'b1;
  bit m_pulse = 1'b0;
  bit m_err  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit ev, ok;
    if (reset) begin
      m_tod = 0; m_cnt = 0; m_prev = 1'b1; m_pulse = 1'b0; m_err = 1'b0;
      return;
    end
    ev = tick_in && !m_prev;
    m_prev = tick_in;
    ok = load && (load_hours <= 23) && (load_minutes <= 59);
    m_pulse = 1'b0;
    m_err = load && !ok;
    if (ok) begin
      m_tod = int'(load_hours) * 3600 + int'(load_minutes) * 60;
      m_cnt = 0;
    end else if (ev) begin
      m_cnt++;
      if (m_cnt == TPS) begin
        m_cnt = 0;
        m_tod = (m_tod + 1) % 86400;
        m_pulse = 1'b1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk($sformatf("%s.hours", tag),   32'(hours),        32'(m_tod / 3600));
    chk($sformatf("%s.minutes", tag), 32'(minutes),      32'((m_tod / 60) % 60));
    chk($sformatf("%s.seconds", tag), 32'(seconds),      32'(m_tod % 60));
    chk($sformatf("%s.pulse", tag),   32'(second_pulse), 32'(m_pulse));
    chk($sformatf("%s.lderr", tag),   32'(load_error),   32'(m_err));
  endtask

  task automatic cycle();
    @(posedge input_clock);
    model_edge();
    #1;
    if (second_pulse) pulse_cnt++;
    check_all("cyc");
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    #1;
    model_edge();
    check_all("rst");
    repeat (n) cycle();
    reset = 1'b0;
  endtask

  task automatic do_load(input int h, input int m);
    load = 1'b1;
    load_hours = 5'(h);
    load_minutes = 6'(m);
    cycle();
    load = 1'b0;
  endtask

  task automatic tick_edges(input int n, input int half);
    for (int i = 0; i < n; i++) begin
      tick_in = 1'b0;
      repeat (half) cycle();
      tick_in = 1'b1;
      repeat (half) cycle();
    end
  endtask

  initial begin
    #2;
    do_reset(3);

    // Slow tick: four rising edges make two seconds.
    pulse_cnt = 0;
    tick_edges(4, 25);
    chk("slow.seconds", 32'(seconds), 32'd2);
    chk("slow.pulses", 32'(pulse_cnt), 32'd2);

    // Out-of-range loads are rejected for one cycle.
    do_load(24, 10);
    chk("bad_h.err", 32'(load_error), 32'd1);
    chk("bad_h.sec", 32'(seconds), 32'd2);
    cycle();
    chk("bad_h.err_clr", 32'(load_error), 32'd0);
    do_load(10, 60);
    chk("bad_m.err", 32'(load_error), 32'd1);
    cycle();

    // Full midnight rollover after 120 events from 23:59.
    do_load(23, 59);
    tick_edges(119, 1);
    chk("mid.pre_hours", 32'(hours), 32'd23);
    chk("mid.pre_seconds", 32'(seconds), 32'd59);
    tick_in = 1'b0; cycle();
    tick_in = 1'b1; cycle();
    chk("mid.hours", 32'(hours), 32'd0);
    chk("mid.minutes", 32'(minutes), 32'd0);
    chk("mid.seconds", 32'(seconds), 32'd0);
    chk("mid.pulse", 32'(second_pulse), 32'd1);

    // Valid load on the exact edge of a second event.
    do_load(1, 2);
    tick_in = 1'b0; cycle();
    tick_in = 1'b1; cycle();
    tick_in = 1'b0; cycle();
    tick_in = 1'b1;
    load = 1'b1; load_hours = 5'd12; load_minutes = 6'd30;
    cycle();
    load = 1'b0;
    chk("ldsec.hours", 32'(hours), 32'd12);
    chk("ldsec.minutes", 32'(minutes), 32'd30);
    chk("ldsec.seconds", 32'(seconds), 32'd0);
    chk("ldsec.pulse", 32'(second_pulse), 32'd0);
    tick_edges(1, 1);
    chk("ldsec.presc", 32'(seconds), 32'd0);
    tick_edges(1, 1);
    chk("ldsec.next", 32'(seconds), 32'd1);

    // Reset mid-count, released with tick_in high.
    tick_in = 1'b0;
    do_reset(2);
    cycle();
    tick_in = 1'b1; cycle();
    do_reset(3);
    pulse_cnt = 0;
    repeat (3) cycle();
    chk("rstmid.hold", 32'(seconds), 32'd0);
    tick_edges(1, 2);
    chk("rstmid.one", 32'(pulse_cnt), 32'd0);
    tick_edges(1, 2);
    chk("rstmid.two", 32'(pulse_cnt), 32'd1);
    chk("rstmid.sec", 32'(seconds), 32'd1);

    // Held-high tick gives only one event.
    tick_in = 1'b0;
    do_reset(2);
    cycle();
    pulse_cnt = 0;
    tick_in = 1'b1;
    repeat (1000) cycle();
    chk("held.pulses", 32'(pulse_cnt), 32'd0);
    tick_edges(1, 1);
    chk("held.sec", 32'(seconds), 32'd1);

    // Random traffic, including loads out of range and occasional resets.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 2) == 0) tick_in = ~tick_in;
      load = ($urandom_range(0, 49) == 0);
      load_hours = 5'($urandom_range(0, 31));
      load_minutes = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 1499) == 0) begin
        load = 1'b0;
        do_reset($urandom_range(1, 3));
      end else begin
        cycle();
      end
    end
    load = 1'b0;
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
